white_pawn_push_serializer: RTL

WHITE_PAWN_PUSH_SERIALIZER -- requirements
Module: white_pawn_push_serializer

---
 rtl/white_pawn_push_serializer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/white_pawn_push_serializer.sv
// White pawn push serializer: latches single/double push target sets on start and streams one move per cycle.
// Latency: first move_valid two cycles after start is sampled; done one cycle after the last accepted move.
// Backpressure: a presented move holds all fields stable until move_valid & move_ready; start is ignored while busy.
module white_pawn_push_serializer #(
  parameter logic [63:0] DOUBLE_RANK_MASK = 64'h00000000FF000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] occupied,
  input  logic [63:0] white_pawn,
  input  logic        move_ready,
  output logic        busy,
  output logic        move_valid,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic        move_double,
  output logic        move_promo,
  output logic        done,
  output logic [4:0]  move_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] single_q, single_d;
  logic [63:0] double_q, double_d;
  logic        valid_q, valid_d;
  logic [5:0]  from_q, from_d;
  logic [5:0]  to_q, to_d;
  logic        dbl_q, dbl_d;
  logic        promo_q, promo_d;
  logic [4:0]  count_q, count_d;

  // Working copies of the remaining sets after removing an accepted move
  logic [63:0] single_rem;
  logic [63:0] double_rem;
  logic        accept;

  // Index of the lowest set bit; callers only use it on a non-zero vector
  function automatic logic [5:0] lsb_idx(input logic [63:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = i[5:0];
    end
    return r;
  endfunction

  // Next-state and next-move computation
  always_comb begin
    state_d    = state_q;
    single_d   = single_q;
    double_d   = double_q;
    valid_d    = valid_q;
    from_d     = from_q;
    to_d       = to_q;
    dbl_d      = dbl_q;
    promo_d    = promo_q;
    count_d    = count_q;
    single_rem = single_q;
    double_rem = double_q;
    accept     = valid_q & move_ready;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          single_d = (white_pawn << 8) & ~occupied;
          double_d = (((white_pawn << 8) & ~occupied) << 8) & ~occupied & DOUBLE_RANK_MASK;
          count_d  = 5'd0;
          state_d  = EMIT;
        end
      end

      EMIT: begin
        // The presented move is always the lowest bit of the first non-empty set,
        // so accepting it just strips that lowest bit.
        if (accept) begin
          if (single_q != 64'd0) begin
            single_rem = single_q & (single_q - 64'd1);
          end else begin
            double_rem = double_q & (double_q - 64'd1);
          end
          if (count_q != 5'd31) count_d = count_q + 5'd1;
        end
        single_d = single_rem;
        double_d = double_rem;

        // Load a new move when nothing is shown or the shown one was just taken
        if (!valid_q || accept) begin
          if (single_rem != 64'd0) begin
            valid_d = 1'b1;
            to_d    = lsb_idx(single_rem);
            from_d  = to_d - 6'd8;
            dbl_d   = 1'b0;
            promo_d = (to_d >= 6'd56);
          end else if (double_rem != 64'd0) begin
            valid_d = 1'b1;
            to_d    = lsb_idx(double_rem);
            from_d  = to_d - 6'd16;
            dbl_d   = 1'b1;
            promo_d = (to_d >= 6'd56);
          end else begin
            valid_d = 1'b0;
            state_d = FIN;
          end
        end
      end

      FIN: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      single_q <= 64'd0;
      double_q <= 64'd0;
      valid_q  <= 1'b0;
      from_q   <= 6'd0;
      to_q     <= 6'd0;
      dbl_q    <= 1'b0;
      promo_q  <= 1'b0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      double_q <= double_d;
      valid_q  <= valid_d;
      from_q   <= from_d;
      to_q     <= to_d;
      dbl_q    <= dbl_d;
      promo_q  <= promo_d;
      count_q  <= count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign move_valid  = valid_q;
  assign move_from   = from_q;
  assign move_to     = to_q;
  assign move_double = dbl_q;
  assign move_promo  = promo_q;
  assign move_count  = count_q;

endmodule
